// File: rtl/bip_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module   : bip_datapath_mc
// Brief    : Parametrised BIP accumulator datapath with an 8-operation ALU,
//            registered Z/N/C/V flags and an optional multi-cycle shift-add
//            multiplier (enabled by defining the macro BIP_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module bip_datapath_mc #(
    parameter int N = 15,
    parameter int A = 10
) (
    input  logic         clk,
    input  logic         Clear,
    input  logic [1:0]   SelA,
    input  logic         SelB,
    input  logic         WrAcc,
    input  logic [2:0]   Op,
    input  logic [A:0]   Addr,
    input  logic [N:0]   Out_Data,
    output logic [N:0]   In_Data,
    output logic [A:0]   Addr_DM,
    output logic         Busy,
    output logic         Done,
    output logic         Zero,
    output logic         Neg,
    output logic         Carry,
    output logic         Ovf
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_SRA = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    logic [N:0]   r_acc;
    logic         r_zero, r_neg, r_carry, r_ovf;
    logic [N:0]   w_addr_sx;
    logic [N:0]   w_b;
    logic [N:0]   w_alu_res;
    logic         w_alu_c;
    logic         w_alu_v;
    logic [N+1:0] w_sum;
    logic         w_busy;
    logic         w_wr;

    assign w_addr_sx = {{(N-A){Addr[A]}}, Addr};
    assign w_b       = SelB ? Out_Data : w_addr_sx;
    assign Addr_DM   = Addr;
    assign In_Data   = r_acc;
    assign Zero      = r_zero;
    assign Neg       = r_neg;
    assign Carry     = r_carry;
    assign Ovf       = r_ovf;

    // ALU: shared adder handles SUB as a + ~b + 1 so Carry means "no borrow"
    always_comb begin
        w_sum     = '0;
        w_alu_res = r_acc;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (Op)
            c_OP_ADD: begin
                w_sum     = {1'b0, r_acc} + {1'b0, w_b};
                w_alu_res = w_sum[N:0];
                w_alu_c   = w_sum[N+1];
                w_alu_v   = (r_acc[N] == w_b[N]) && (w_sum[N] != r_acc[N]);
            end
            c_OP_SUB: begin
                w_sum     = {1'b0, r_acc} + {1'b0, ~w_b} + {{(N+1){1'b0}}, 1'b1};
                w_alu_res = w_sum[N:0];
                w_alu_c   = w_sum[N+1];
                w_alu_v   = (r_acc[N] != w_b[N]) && (w_sum[N] != r_acc[N]);
            end
            c_OP_AND: w_alu_res = r_acc & w_b;
            c_OP_OR:  w_alu_res = r_acc | w_b;
            c_OP_XOR: w_alu_res = r_acc ^ w_b;
            c_OP_SHL: begin
                w_alu_res = {r_acc[N-1:0], 1'b0};
                w_alu_c   = r_acc[N];
            end
            c_OP_SRA: begin
                w_alu_res = {r_acc[N], r_acc[N:1]};
                w_alu_c   = r_acc[0];
            end
            default: w_alu_res = r_acc;
        endcase
    end

    // Single-cycle writes never start while a multiply owns the accumulator;
    // SelA=00 with MUL is routed to the multiplier (or ignored without it)
    assign w_wr = WrAcc && !w_busy && (SelA != 2'b11) &&
                  !((SelA == 2'b00) && (Op == c_OP_MUL));

`ifdef BIP_MUL_EN
    localparam int        c_CW   = $clog2(N + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [N:0]      r_mcand, r_mplier, r_prod;
    logic [N:0]      w_prod_step;
    logic            r_done;
    logic            w_issue, w_last;

    assign w_busy      = (r_state == ST_MUL);
    assign w_issue     = WrAcc && (SelA == 2'b00) && (Op == c_OP_MUL) && !w_busy;
    assign w_last      = w_busy && (r_cnt == c_LAST);
    assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign Busy        = w_busy;
    assign Done        = r_done;

    // Multiplier state register
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: stay in ST_MUL for N+1 iterations after issue
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_last)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift-add datapath: one multiplier bit consumed per clock
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_issue) begin
                r_cnt    <= '0;
                r_mcand  <= r_acc;
                r_mplier <= w_b;
                r_prod   <= '0;
            end else if (w_busy) begin
                r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                r_mcand  <= {r_mcand[N-1:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[N:1]};
                r_prod   <= w_prod_step;
            end
        end
    end
`else
    assign w_busy = 1'b0;
    assign Busy   = 1'b0;
    assign Done   = 1'b0;
`endif

    // Accumulator and flags; MUL completion takes priority over normal writes
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            r_acc   <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
`ifdef BIP_MUL_EN
            if (w_last) begin
                r_acc   <= w_prod_step;
                r_zero  <= (w_prod_step == '0);
                r_neg   <= w_prod_step[N];
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
            end else
`endif
            if (w_wr) begin
                case (SelA)
                    2'b00: begin
                        r_acc   <= w_alu_res;
                        r_zero  <= (w_alu_res == '0);
                        r_neg   <= w_alu_res[N];
                        r_carry <= w_alu_c;
                        r_ovf   <= w_alu_v;
                    end
                    2'b01: begin
                        r_acc  <= w_addr_sx;
                        r_zero <= (w_addr_sx == '0);
                        r_neg  <= w_addr_sx[N];
                    end
                    default: begin
                        r_acc  <= Out_Data;
                        r_zero <= (Out_Data == '0);
                        r_neg  <= Out_Data[N];
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bip_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_datapath_mc
// Brief    : Directed self-checking bench for bip_datapath_mc (N=15, A=10).
//            Multiplier scenarios follow the BIP_MUL_EN build macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bip_datapath_mc;

    logic        clk;
    logic        Clear;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic [2:0]  Op;
    logic [10:0] Addr;
    logic [15:0] Out_Data;
    logic [15:0] In_Data;
    logic [10:0] Addr_DM;
    logic        Busy, Done, Zero, Neg, Carry, Ovf;

    int tests_run = 0;
    int tests_failed = 0;

    bip_datapath_mc #(.N(15), .A(10)) dut (
        .clk(clk), .Clear(Clear), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
        .Op(Op), .Addr(Addr), .Out_Data(Out_Data), .In_Data(In_Data),
        .Addr_DM(Addr_DM), .Busy(Busy), .Done(Done), .Zero(Zero), .Neg(Neg),
        .Carry(Carry), .Ovf(Ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation across one rising edge, then sample 1 ns later
    task automatic step(input logic [1:0] sa, input logic sb, input logic wr,
                        input logic [2:0] op, input logic [10:0] ad,
                        input logic [15:0] od);
        SelA = sa; SelB = sb; WrAcc = wr; Op = op; Addr = ad; Out_Data = od;
        @(posedge clk); #1;
        WrAcc = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        step(2'b10, 1'b0, 1'b1, 3'b000, 11'h000, v);
    endtask

    task automatic test_reset;
        load(16'h7FFF);
        step(2'b00, 1'b1, 1'b1, 3'b000, 11'h000, 16'h0001);   // -> 8000, V=1
        load(16'h1234);
        tests_run++;
        if (In_Data !== 16'h1234 || Ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: acc=%h ovf=%b, want acc=1234 ovf=1", In_Data, Ovf);
        end
        #2 Clear = 1'b0;
        #1;
        tests_run++;
        if (In_Data !== 16'h0000 || {Zero, Neg, Carry, Ovf} !== 4'b0000 ||
            Busy !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: acc=%h znvc=%b%b%b%b busy=%b done=%b, want all 0",
                     In_Data, Zero, Neg, Carry, Ovf, Busy, Done);
        end
        @(negedge clk) Clear = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_add;
        step(2'b01, 1'b0, 1'b1, 3'b000, 11'h7FF, 16'h0000);
        tests_run++;
        if (In_Data !== 16'hFFFF || Neg !== 1'b1 || Zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_sx: acc=%h n=%b z=%b, want FFFF n=1 z=0", In_Data, Neg, Zero);
        end
        tests_run++;
        if (Addr_DM !== 11'h7FF) begin
            tests_failed++;
            $display("FAIL addr_dm: got %h want 7FF", Addr_DM);
        end
        step(2'b00, 1'b0, 1'b1, 3'b000, 11'h001, 16'h0000);
        tests_run++;
        if (In_Data !== 16'h0000 || Zero !== 1'b1 || Carry !== 1'b1 || Ovf !== 1'b0 ||
            Neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_wrap: acc=%h znvc=%b%b%b%b, want 0000 z1 n0 c1 v0",
                     In_Data, Zero, Neg, Carry, Ovf);
        end
    endtask

    task automatic test_overflow_sub;
        load(16'h7FFF);
        step(2'b00, 1'b1, 1'b1, 3'b000, 11'h000, 16'h0001);
        tests_run++;
        if (In_Data !== 16'h8000 || Ovf !== 1'b1 || Neg !== 1'b1 || Carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_ovf: acc=%h n=%b c=%b v=%b, want 8000 n1 c0 v1",
                     In_Data, Neg, Carry, Ovf);
        end
        step(2'b01, 1'b0, 1'b1, 3'b000, 11'h000, 16'h0000);
        tests_run++;
        if (In_Data !== 16'h0000 || Zero !== 1'b1 || Ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_hold_cv: acc=%h z=%b v=%b, want 0000 z1 v1(held)",
                     In_Data, Zero, Ovf);
        end
        step(2'b00, 1'b0, 1'b1, 3'b001, 11'h001, 16'h0000);
        tests_run++;
        if (In_Data !== 16'hFFFF || Carry !== 1'b0 || Ovf !== 1'b0 || Neg !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_borrow: acc=%h n=%b c=%b v=%b, want FFFF n1 c0 v0",
                     In_Data, Neg, Carry, Ovf);
        end
        load(16'h8000);
        step(2'b00, 1'b0, 1'b1, 3'b001, 11'h001, 16'h0000);
        tests_run++;
        if (In_Data !== 16'h7FFF || Carry !== 1'b1 || Ovf !== 1'b1 || Neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_ovf: acc=%h n=%b c=%b v=%b, want 7FFF n0 c1 v1",
                     In_Data, Neg, Carry, Ovf);
        end
        step(2'b11, 1'b1, 1'b1, 3'b000, 11'h000, 16'h1111);
        step(2'b10, 1'b1, 1'b0, 3'b000, 11'h000, 16'h2222);
        tests_run++;
        if (In_Data !== 16'h7FFF || Carry !== 1'b1 || Ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold: acc=%h c=%b v=%b, want 7FFF c1 v1", In_Data, Carry, Ovf);
        end
    endtask

    task automatic test_shift_logic;
        load(16'h8001);
        step(2'b00, 1'b0, 1'b1, 3'b110, 11'h000, 16'h0000);
        tests_run++;
        if (In_Data !== 16'hC000 || Carry !== 1'b1 || Ovf !== 1'b0 || Neg !== 1'b1) begin
            tests_failed++;
            $display("FAIL sra1: acc=%h n=%b c=%b v=%b, want C000 n1 c1 v0",
                     In_Data, Neg, Carry, Ovf);
        end
        load(16'h8001);
        step(2'b00, 1'b0, 1'b1, 3'b101, 11'h000, 16'h0000);
        tests_run++;
        if (In_Data !== 16'h0002 || Carry !== 1'b1 || Neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL shl1: acc=%h n=%b c=%b, want 0002 n0 c1", In_Data, Neg, Carry);
        end
        load(16'h00FF);
        step(2'b00, 1'b1, 1'b1, 3'b100, 11'h000, 16'hFFFF);
        tests_run++;
        if (In_Data !== 16'hFF00 || Carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL xor: acc=%h c=%b, want FF00 c0", In_Data, Carry);
        end
        step(2'b00, 1'b1, 1'b1, 3'b010, 11'h000, 16'h0F0F);
        tests_run++;
        if (In_Data !== 16'h0F00) begin
            tests_failed++;
            $display("FAIL and: got %h want 0F00", In_Data);
        end
        step(2'b00, 1'b0, 1'b1, 3'b011, 11'h0F0, 16'h0000);
        tests_run++;
        if (In_Data !== 16'h0FF0) begin
            tests_failed++;
            $display("FAIL or: got %h want 0FF0", In_Data);
        end
    endtask

`ifdef BIP_MUL_EN
    // Waits for the multiply to finish; returns busy cycles seen and Done pulses
    task automatic wait_mul(output int busy_cnt, output int done_cnt);
        busy_cnt = 1;   // Busy already observed after the issue edge
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            WrAcc = 1'b1; SelA = 2'b01; Addr = 11'(i * 37); Out_Data = 16'(i * 911);
            @(posedge clk); #1;
            if (Done) done_cnt++;
            if (!Busy) break;
            busy_cnt++;
        end
        WrAcc = 1'b0;
    endtask

    task automatic test_mul;
        int bc, dc;
        load(16'd300);
        step(2'b00, 1'b1, 1'b1, 3'b111, 11'h000, 16'd7);
        tests_run++;
        if (Busy !== 1'b1 || In_Data !== 16'd300) begin
            tests_failed++;
            $display("FAIL mul_issue: busy=%b acc=%h, want busy=1 acc=012C", Busy, In_Data);
        end
        wait_mul(bc, dc);
        tests_run++;
        if (bc != 16 || dc != 1 || Done !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_timing: busy_cycles=%0d dones=%0d done_now=%b, want 16 1 1",
                     bc, dc, Done);
        end
        tests_run++;
        if (In_Data !== 16'h0834 || {Zero, Neg, Carry, Ovf} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mul_300x7: acc=%h znvc=%b%b%b%b, want 0834 0000",
                     In_Data, Zero, Neg, Carry, Ovf);
        end
        @(posedge clk); #1;
        tests_run++;
        if (Done !== 1'b0 || In_Data !== 16'h0834) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b acc=%h, want done=0 acc=0834", Done, In_Data);
        end
        // Signed operand, immediate multiplier
        step(2'b01, 1'b0, 1'b1, 3'b000, 11'h7FD, 16'h0000);
        step(2'b00, 1'b0, 1'b1, 3'b111, 11'h005, 16'h0000);
        wait_mul(bc, dc);
        tests_run++;
        if (In_Data !== 16'hFFF1 || Neg !== 1'b1 || Zero !== 1'b0 || dc != 1) begin
            tests_failed++;
            $display("FAIL mul_neg: acc=%h n=%b z=%b dones=%0d, want FFF1 n1 z0 1",
                     In_Data, Neg, Zero, dc);
        end
    endtask

    task automatic test_back_to_back;
        int bc, dc;
        load(16'h0123);
        step(2'b00, 1'b0, 1'b1, 3'b111, 11'h002, 16'h0000);
        wait_mul(bc, dc);
        // Issue again on the edge where Done is high: ACC(0246) x 0
        step(2'b00, 1'b1, 1'b1, 3'b111, 11'h000, 16'h0000);
        tests_run++;
        if (Busy !== 1'b1 || In_Data !== 16'h0246) begin
            tests_failed++;
            $display("FAIL b2b_issue: busy=%b acc=%h, want busy=1 acc=0246", Busy, In_Data);
        end
        wait_mul(bc, dc);
        tests_run++;
        if (In_Data !== 16'h0000 || Zero !== 1'b1 || bc != 16) begin
            tests_failed++;
            $display("FAIL mul_zero: acc=%h z=%b busy_cycles=%0d, want 0000 z1 16",
                     In_Data, Zero, bc);
        end
    endtask

    task automatic test_abort;
        int dc;
        load(16'd300);
        step(2'b00, 1'b1, 1'b1, 3'b111, 11'h000, 16'd7);
        repeat (5) begin @(posedge clk); #1; end
        #2 Clear = 1'b0;
        #1;
        tests_run++;
        if (Busy !== 1'b0 || In_Data !== 16'h0000 || Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: busy=%b acc=%h done=%b, want 0 0000 0", Busy, In_Data, Done);
        end
        @(negedge clk) Clear = 1'b1;
        dc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (Done || Busy) dc++;
        end
        tests_run++;
        if (dc != 0 || In_Data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL abort_quiet: busy/done cycles=%0d acc=%h, want 0 0000", dc, In_Data);
        end
    endtask
`else
    task automatic test_no_mul;
        int bc;
        load(16'h8000);
        step(2'b00, 1'b0, 1'b1, 3'b101, 11'h000, 16'h0000);   // -> 0000 z1 c1
        load(16'h1234);
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'(i), 1'b1, 3'b111, 11'h003, 16'h0005);
            if (Busy || Done) bc++;
        end
        tests_run++;
        if (In_Data !== 16'h1234 || {Zero, Neg, Carry, Ovf} !== 4'b0010 || bc != 0) begin
            tests_failed++;
            $display("FAIL no_mul: acc=%h znvc=%b%b%b%b busy/done=%0d, want 1234 0010 0",
                     In_Data, Zero, Neg, Carry, Ovf, bc);
        end
    endtask
`endif

    initial begin
        Clear = 1'b0; SelA = 2'b11; SelB = 1'b0; WrAcc = 1'b0; Op = 3'b000;
        Addr = '0; Out_Data = '0;
        #3;
        tests_run++;
        if (In_Data !== 16'h0000 || Busy !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_reset: acc=%h busy=%b done=%b, want 0 0 0", In_Data, Busy, Done);
        end
        @(negedge clk) Clear = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_load_add;
        test_overflow_sub;
        test_shift_logic;
`ifdef BIP_MUL_EN
        test_mul;
        test_back_to_back;
        test_abort;
`else
        test_no_mul;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
